// File: rtl/sdram_request_arbiter.sv
// sdram_request_arbiter: burst-granular fixed-priority arbiter (flash over core) onto one SDRAM controller port
module sdram_request_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 22
) (
    input  logic                     i_Clk,
    input  logic                     i_Reset,
    input  logic                     i_CORE_Valid,
    input  logic                     i_CORE_Read_Write_n,
    input  logic [ADDRESS_WIDTH-2:0] i_CORE_Address,
    input  logic [DATA_WIDTH-1:0]    i_CORE_Data,
    output logic                     o_CORE_Valid,
    output logic                     o_CORE_Data_Read,
    output logic                     o_CORE_Last,
    output logic [DATA_WIDTH-1:0]    o_CORE_Data,
    input  logic                     i_Flash_Valid,
    input  logic [DATA_WIDTH-1:0]    i_Flash_Data,
    input  logic [ADDRESS_WIDTH-1:0] i_Flash_Address,
    output logic                     o_Flash_Data_Read,
    output logic                     o_Flash_Last,
    output logic                     o_MEM_Valid,
    output logic [ADDRESS_WIDTH-1:0] o_MEM_Address,
    output logic                     o_MEM_Read_Write_n,
    output logic [DATA_WIDTH-1:0]    o_MEM_Data,
    input  logic                     i_MEM_Data_Read,
    input  logic [DATA_WIDTH-1:0]    i_MEM_Data,
    input  logic                     i_MEM_Data_Valid,
    input  logic                     i_MEM_Last
);
    typedef enum logic [1:0] {IDLE, SERVE_FLASH, SERVE_CORE} state_t;
    state_t state_q, state_d;
    logic flash_g, core_g;
    assign flash_g = state_q == SERVE_FLASH;
    assign core_g  = state_q == SERVE_CORE;
    // A grant lasts until the controller signals the final beat, regardless of the master's valid.
    always_comb begin
        state_d = state_q;
        if (state_q == IDLE)
            state_d = i_Flash_Valid ? SERVE_FLASH : i_CORE_Valid ? SERVE_CORE : IDLE;
        else if (i_MEM_Last)
            state_d = IDLE;
    end
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) state_q <= IDLE;
        else         state_q <= state_d;
    end
    assign o_MEM_Valid        = flash_g ? i_Flash_Valid : core_g && i_CORE_Valid;
    assign o_MEM_Address      = flash_g ? i_Flash_Address : core_g ? {1'b0, i_CORE_Address} : '0;
    assign o_MEM_Data         = flash_g ? i_Flash_Data : core_g ? i_CORE_Data : '0;
    assign o_MEM_Read_Write_n = flash_g ? 1'b0 : core_g ? i_CORE_Read_Write_n : 1'b1;
    assign o_CORE_Data        = i_MEM_Data;
    assign o_CORE_Valid       = core_g && i_MEM_Data_Valid;
    assign o_CORE_Data_Read   = core_g && i_MEM_Data_Read;
    assign o_CORE_Last        = core_g && i_MEM_Last;
    assign o_Flash_Data_Read  = flash_g && i_MEM_Data_Read;
    assign o_Flash_Last       = flash_g && i_MEM_Last;
endmodule

// File: tb/tb_sdram_request_arbiter.sv
// tb_sdram_request_arbiter: directed test-plan scenarios plus random traffic against an ownership model
module tb_sdram_request_arbiter;
    logic        i_Clk = 0, i_Reset = 1;
    logic        i_CORE_Valid = 0, i_CORE_Read_Write_n = 0;
    logic [20:0] i_CORE_Address = 0;
    logic [31:0] i_CORE_Data = 0;
    logic        o_CORE_Valid, o_CORE_Data_Read, o_CORE_Last;
    logic [31:0] o_CORE_Data;
    logic        i_Flash_Valid = 0;
    logic [31:0] i_Flash_Data = 0;
    logic [21:0] i_Flash_Address = 0;
    logic        o_Flash_Data_Read, o_Flash_Last;
    logic        o_MEM_Valid, o_MEM_Read_Write_n;
    logic [21:0] o_MEM_Address;
    logic [31:0] o_MEM_Data;
    logic        i_MEM_Data_Read = 0, i_MEM_Data_Valid = 0, i_MEM_Last = 0;
    logic [31:0] i_MEM_Data = 0;
    int total = 0, bad = 0;
    int owner = 0; // 0 nobody, 1 flash, 2 core
    int flash_dr_n = 0, flash_last_n = 0, core_valid_n = 0;

    sdram_request_arbiter dut (
        .i_Clk(i_Clk), .i_Reset(i_Reset),
        .i_CORE_Valid(i_CORE_Valid), .i_CORE_Read_Write_n(i_CORE_Read_Write_n),
        .i_CORE_Address(i_CORE_Address), .i_CORE_Data(i_CORE_Data),
        .o_CORE_Valid(o_CORE_Valid), .o_CORE_Data_Read(o_CORE_Data_Read),
        .o_CORE_Last(o_CORE_Last), .o_CORE_Data(o_CORE_Data),
        .i_Flash_Valid(i_Flash_Valid), .i_Flash_Data(i_Flash_Data),
        .i_Flash_Address(i_Flash_Address), .o_Flash_Data_Read(o_Flash_Data_Read),
        .o_Flash_Last(o_Flash_Last), .o_MEM_Valid(o_MEM_Valid),
        .o_MEM_Address(o_MEM_Address), .o_MEM_Read_Write_n(o_MEM_Read_Write_n),
        .o_MEM_Data(o_MEM_Data), .i_MEM_Data_Read(i_MEM_Data_Read),
        .i_MEM_Data(i_MEM_Data), .i_MEM_Data_Valid(i_MEM_Data_Valid),
        .i_MEM_Last(i_MEM_Last)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Expected request bundle {valid, address, rw_n, data} for whoever owns the controller.
    function automatic logic [55:0] exp_mem();
        if (owner == 1) return {i_Flash_Valid, i_Flash_Address, 1'b0, i_Flash_Data};
        if (owner == 2) return {i_CORE_Valid, 1'b0, i_CORE_Address, i_CORE_Read_Write_n, i_CORE_Data};
        return {1'b0, 22'd0, 1'b1, 32'd0};
    endfunction

    function automatic logic [36:0] exp_rsp();
        logic c, f;
        c = owner == 2;
        f = owner == 1;
        return {c & i_MEM_Data_Valid, c & i_MEM_Data_Read, c & i_MEM_Last,
                f & i_MEM_Data_Read, f & i_MEM_Last, i_MEM_Data};
    endfunction

    // Called just after a falling edge with inputs applied: check, let one rising edge pass, advance model.
    task automatic tick();
        #1;
        if (i_Reset) owner = 0;
        chk("mem", {o_MEM_Valid, o_MEM_Address, o_MEM_Read_Write_n, o_MEM_Data}, exp_mem());
        chk("rsp", {o_CORE_Valid, o_CORE_Data_Read, o_CORE_Last, o_Flash_Data_Read, o_Flash_Last, o_CORE_Data}, exp_rsp());
        flash_dr_n   += int'(o_Flash_Data_Read);
        flash_last_n += int'(o_Flash_Last);
        core_valid_n += int'(o_CORE_Valid);
        @(posedge i_Clk);
        if (i_Reset) owner = 0;
        else if (owner == 0) owner = i_Flash_Valid ? 1 : i_CORE_Valid ? 2 : 0;
        else if (i_MEM_Last) owner = 0;
        @(negedge i_Clk);
    endtask

    task automatic mem_rsp(input logic dr, input logic dv, input logic last, input logic [31:0] d);
        i_MEM_Data_Read = dr; i_MEM_Data_Valid = dv; i_MEM_Last = last; i_MEM_Data = d;
    endtask

    initial begin
        @(negedge i_Clk);
        tick();
        i_Reset = 0;
        // idle after reset release
        repeat (10) tick();
        // flash write 0xDEADBEEF @ 0x10, Data_Read at cycle 3, Last at cycle 4
        flash_dr_n = 0; flash_last_n = 0; core_valid_n = 0;
        i_Flash_Valid = 1; i_Flash_Address = 22'h000010; i_Flash_Data = 32'hDEADBEEF;
        tick(); tick();
        chk("flash_rw", {63'd0, o_MEM_Read_Write_n}, 64'd0);
        chk("flash_addr", {42'd0, o_MEM_Address}, 64'h10);
        tick();
        mem_rsp(1, 0, 0, 0); tick();
        mem_rsp(0, 0, 1, 0); tick();
        mem_rsp(0, 0, 0, 0); i_Flash_Valid = 0; tick(); tick();
        chk("flash_dr_cnt", 64'(flash_dr_n), 64'd1);
        chk("flash_last_cnt", 64'(flash_last_n), 64'd1);
        chk("flash_core_quiet", 64'(core_valid_n), 64'd0);
        // core read @ 0x1FFFFF, two beats
        core_valid_n = 0;
        i_CORE_Valid = 1; i_CORE_Read_Write_n = 1; i_CORE_Address = 21'h1FFFFF;
        tick();
        chk("core_addr", {42'd0, o_MEM_Address}, 64'h1FFFFF);
        mem_rsp(0, 1, 0, 32'h11111111); tick();
        mem_rsp(0, 1, 1, 32'h22222222);
        #1 chk("core_last_beat", {62'd0, o_CORE_Last, o_CORE_Valid}, 64'd3);
        chk("core_beat2", {32'd0, o_CORE_Data}, 64'h22222222);
        tick();
        mem_rsp(0, 0, 0, 0); i_CORE_Valid = 0; tick();
        chk("core_beats", 64'(core_valid_n), 64'd2);
        // simultaneous requests: flash first
        i_CORE_Valid = 1; i_CORE_Read_Write_n = 0; i_CORE_Address = 21'h00ABC; i_CORE_Data = 32'hC0DEC0DE;
        i_Flash_Valid = 1; i_Flash_Address = 22'h3FFFFF; i_Flash_Data = 32'h5A5A5A5A;
        tick();
        chk("prio_flash", {62'd0, o_MEM_Valid, o_MEM_Read_Write_n}, 64'd2);
        mem_rsp(1, 0, 1, 0); tick();
        mem_rsp(0, 0, 0, 0); i_Flash_Valid = 0; tick();
        chk("core_after_flash", {42'd0, o_MEM_Address}, 64'h00ABC);
        // core drops valid mid-burst; grant held until Last
        mem_rsp(1, 0, 0, 0); tick();
        mem_rsp(0, 0, 0, 0); i_CORE_Valid = 0; tick();
        chk("core_hold", {42'd0, o_MEM_Address}, 64'h00ABC);
        tick();
        mem_rsp(1, 0, 1, 0); tick();
        mem_rsp(0, 0, 0, 0); tick();
        // reset mid core burst with flash pending
        i_CORE_Valid = 1; i_CORE_Read_Write_n = 1; tick(); tick();
        i_Flash_Valid = 1;
        #2 i_Reset = 1;
        #1 chk("rst_async", {62'd0, o_MEM_Valid, o_MEM_Read_Write_n}, 64'd1);
        @(negedge i_Clk);
        tick();
        i_Reset = 0;
        tick();
        chk("rst_flash_first", {62'd0, o_MEM_Valid, o_MEM_Read_Write_n}, 64'd2);
        mem_rsp(0, 0, 1, 0); tick();
        i_Flash_Valid = 0; i_CORE_Valid = 0; mem_rsp(0, 0, 0, 0); tick();
        // random traffic
        for (int i = 0; i < 400; i++) begin
            i_Flash_Valid = $urandom_range(0, 3) == 0;
            i_CORE_Valid = $urandom_range(0, 2) == 0;
            i_CORE_Read_Write_n = 1'($urandom);
            i_CORE_Address = 21'($urandom);
            i_CORE_Data = $urandom;
            i_Flash_Address = 22'($urandom);
            i_Flash_Data = $urandom;
            mem_rsp(1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0, $urandom);
            if (i % 97 == 50) begin
                #2 i_Reset = 1;
                @(negedge i_Clk);
                tick();
                i_Reset = 0;
            end
            tick();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
